debug_display_scanner: RTL
==========================

Name: debug_display_scanner

Overview:
- Parametrised, clocked successor to the board debug-display selector.
- Picks one of N 32-bit-class datapath probe words (IMEM, REG, ALU, status, DMEM, control, ALU control, EPC, ...) and presents it as nibbles for the 8-digit hex display, with a channel index digit and a PC byte.
- Adds registered outputs, an auto-scan mode with programmable dwell, a freeze/snapshot mode, invalid-select detection and a change strobe.
- Sits between the CPU probe bus and the display driver.

Parameters:
- N_CH, 8, number of probe channels (2..16).
- DATA_W, 32, probe word width; must be a multiple of 4.
- PC_W, 8, width of the PC passthrough.
- IDX_W, 4, width of the channel-index output; 2^IDX_W >= N_CH.
- DWELL, 50000000, auto-scan cycles per channel (>= 1).
- CNT_W, 26, dwell counter width; 2^CNT_W >= DWELL.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ch_data  in  N_CH*DATA_W  probe words; channel k occupies [k*DATA_W +: DATA_W].
- pc  in  PC_W  program counter low bits.
- sel_onehot  in  N_CH  manual channel select, one-hot.
- mode  in  2  00 manual, 01 auto-scan, 10 freeze, 11 treated as manual.
- chan_idx  out  IDX_W  index of the displayed channel (the "oy" digit).
- nib_out  out  DATA_W  displayed word; nibble j = nib_out[4j+3:4j] drives digit j+1.
- pc_out  out  PC_W  registered PC (the LED/segment bits).
- update  out  1  one-cycle pulse when chan_idx changes.
- sel_err  out  1  high for each cycle in which manual mode sees an invalid sel_onehot.

Behaviour:
- Reset (async assert, sync-released use): chan_idx=0, nib_out=0, pc_out=0, update=0, sel_err=0, dwell counter=0, mode_q=manual.
- All outputs are registered. Latency is 1 cycle from sampled inputs to outputs.
- Each edge, next_idx is computed from the mode. Then:
  - chan_idx <= next_idx.
  - nib_out <= ch_data slice at next_idx.
  - pc_out <= pc.
  - update <= (next_idx != chan_idx).
- Manual (mode 00/11):
  - If sel_onehot has exactly one bit set at position k, next_idx = k.
  - If sel_onehot is zero or has multiple bits set, next_idx = chan_idx (hold) and sel_err <= 1. Otherwise sel_err <= 0.
  - Dwell counter is held at 0.
- Auto-scan (mode 01):
  - The counter increments every cycle.
  - When the counter == DWELL-1, it clears to 0 and next_idx = chan_idx+1, wrapping from N_CH-1 to 0. Otherwise next_idx = chan_idx.
  - sel_onehot is ignored and sel_err <= 0.
  - On the first cycle after entering auto (mode_q != 01), the counter restarts from 0 and scanning begins from the current chan_idx.
  - DWELL=1 advances every cycle.
- Freeze (mode 10):
  - chan_idx, nib_out, pc_out and the counter hold their values.
  - update <= 0 and sel_err <= 0.
  - Live data changes are not shown.
  - Leaving freeze resumes the target mode on the next edge; auto restarts the dwell count.
- mode_q <= mode every edge; it is used only for entry detection.
- chan_idx never exceeds N_CH-1.
- Channel indices >= N_CH are unreachable and need no decode.
- Reset asserted mid-scan or mid-freeze returns to the reset state immediately; the next non-reset edge behaves as manual entry.

Test Plan:
- Reset, then mode=00, sel_onehot=8'h04, ch_data ch2=32'hDEADBEEF, pc=8'h3C → after 1 edge: chan_idx=2, nib_out=32'hDEADBEEF, pc_out=8'h3C, update=1 for 1 cycle, sel_err=0.
- Manual at ch2, then sel_onehot=8'h06 → chan_idx stays 2, sel_err=1; then sel_onehot=8'h00 → chan_idx stays 2, sel_err=1; then 8'h80 → chan_idx=7, sel_err=0, update=1.
- DWELL=4, mode=01 from chan_idx=6 → chan_idx is 7 after 4 edges, 0 after 8 (wrap), 1 after 12; update pulses exactly at each change.
- Manual ch1 showing 32'h12345678, mode=10, then ch1 changes to 32'hFFFFFFFF and pc toggles → nib_out stays 32'h12345678 and pc_out is held; return to 00 → next edge nib_out=32'hFFFFFFFF.
- Auto-scan mid-dwell (counter=2), rst pulsed asynchronously between edges → outputs go to 0 immediately without a clock; after release with mode=01, the first advance occurs DWELL edges later.
- Auto at counter=3 (terminal), mode switched to 10 on that edge → no advance, chan_idx held; switch to 01 → a full 4-cycle dwell before the next advance.

Source files
------------

// File: rtl/debug_display_scanner.sv
// Debug display scanner: selects one probe word for the hex display, either by
// a manual one-hot select or by timed auto-scan, with a freeze mode and a change strobe.
module debug_display_scanner #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int IDX_W  = 4,
  parameter int DWELL  = 50000000,
  parameter int CNT_W  = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [PC_W-1:0]          pc,
  input  logic [N_CH-1:0]          sel_onehot,
  input  logic [1:0]               mode,
  output logic [IDX_W-1:0]         chan_idx,
  output logic [DATA_W-1:0]        nib_out,
  output logic [PC_W-1:0]          pc_out,
  output logic                     update,
  output logic                     sel_err
);

  localparam logic [1:0]       MODE_AUTO = 2'b01;
  localparam logic [1:0]       MODE_FRZ  = 2'b10;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_TERM  = CNT_W'(DWELL - 1);

  // Returns {exactly_one_bit_set, index_of_highest_set_bit}.
  function automatic logic [IDX_W:0] decode_onehot(input logic [N_CH-1:0] sel);
    logic [IDX_W-1:0] idx;
    int unsigned      hits;
    idx  = '0;
    hits = 32'd0;
    for (int k = 0; k < N_CH; k++) begin
      idx  = sel[k] ? IDX_W'(k) : idx;
      hits = hits + 32'(sel[k]);
    end
    return {(hits == 32'd1), idx};
  endfunction

  logic [IDX_W-1:0]  chan_idx_q, chan_idx_d;
  logic [DATA_W-1:0] nib_q, nib_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              update_q, update_d;
  logic              sel_err_q, sel_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q;

  logic [IDX_W:0]    dec_s;
  logic [CNT_W-1:0]  cnt_cur_s;
  logic [DATA_W-1:0] word_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_idx_q <= '0;
      nib_q      <= '0;
      pc_q       <= '0;
      update_q   <= 1'b0;
      sel_err_q  <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= 2'b00;
    end else begin
      chan_idx_q <= chan_idx_d;
      nib_q      <= nib_d;
      pc_q       <= pc_d;
      update_q   <= update_d;
      sel_err_q  <= sel_err_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode;
    end
  end

  // A fresh entry into auto-scan restarts the dwell count from zero.
  assign cnt_cur_s = (mode_q == MODE_AUTO) ? cnt_q : '0;
  assign dec_s     = decode_onehot(sel_onehot);

  always_comb begin
    chan_idx_d = chan_idx_q;
    cnt_d      = cnt_q;
    sel_err_d  = 1'b0;
    case (mode)
      MODE_AUTO: begin
        if (cnt_cur_s == CNT_TERM) begin
          cnt_d      = '0;
          chan_idx_d = (chan_idx_q == LAST_IDX) ? '0 : chan_idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_cur_s + CNT_W'(1);
        end
      end
      MODE_FRZ: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = '0;
        if (dec_s[IDX_W]) begin
          chan_idx_d = dec_s[IDX_W-1:0];
        end else begin
          sel_err_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    word_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      word_s = (chan_idx_d == IDX_W'(k)) ? ch_data[k*DATA_W +: DATA_W] : word_s;
    end
  end

  // Freeze keeps every displayed value and suppresses the change strobe.
  always_comb begin
    if (mode == MODE_FRZ) begin
      nib_d    = nib_q;
      pc_d     = pc_q;
      update_d = 1'b0;
    end else begin
      nib_d    = word_s;
      pc_d     = pc;
      update_d = (chan_idx_d != chan_idx_q);
    end
  end

  assign chan_idx = chan_idx_q;
  assign nib_out  = nib_q;
  assign pc_out   = pc_q;
  assign update   = update_q;
  assign sel_err  = sel_err_q;

endmodule
